cache_victim_writeback: RTL and testbench
=========================================

Name: cache_victim_writeback

Overview:
Consumer side of the replacement-policy victim interface. Accepts the one-hot victim way chosen by the replacement logic (random/LFSR or LRU) together with that way's line data, dirty bit and line address. If the victim is dirty, buffers the line and drains it to the bus as a sequence of beats with a valid/ready handshake. Then reports completion and tells the cache to clear the victim's dirty bit. Sits between the cache tag/data arrays and the bus interface, beside the cache FSM.

Parameters:
NUMWAYS, 4, associativity; width of one-hot way vectors
LINELEN, 256, cache line width in bits
BEATLEN, 64, bus data width in bits; LINELEN must be an integer multiple of BEATLEN
PA_BITS, 32, physical address width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
EvictReq  input  1  single-cycle start pulse from the cache FSM; honoured only in IDLE
VictimWay  input  NUMWAYS  one-hot victim from the replacement logic; sampled with EvictReq
VictimDirty  input  1  dirty bit of the selected victim line; sampled with EvictReq
VictimLine  input  LINELEN  data of the selected victim line; sampled with EvictReq
VictimAdr  input  PA_BITS  line-aligned address of the victim; sampled with EvictReq
BusReady  input  1  bus accepts the current beat this cycle
BusValid  output  1  beat on BusAdr/BusWData is valid
BusAdr  output  PA_BITS  byte address of the current beat
BusWData  output  BEATLEN  current beat data
BusLast  output  1  current beat is the final beat of the line
EvictBusy  output  1  block is not in IDLE
EvictDone  output  1  one-cycle completion pulse
ClearDirty  output  1  one-cycle pulse: clear the dirty bit of ClearWay
ClearWay  output  NUMWAYS  latched victim way, valid while ClearDirty=1

Behaviour:
- BEATS = LINELEN/BEATLEN. The beat counter is clog2(BEATS) bits wide, with a minimum of 1.
- Reset: state=IDLE, beat counter=0, all outputs 0, buffer contents don't-care. Because reset is asynchronous, BusValid drops immediately on reset, even mid-burst. There is no partial-completion pulse.
- State IDLE:
  - EvictBusy=0, BusValid=0.
  - On EvictReq with VictimDirty=1 and VictimWay≠0: latch VictimLine, VictimAdr and VictimWay; clear the beat counter; go to WRITE.
  - On EvictReq with a clean victim (VictimDirty=0 or VictimWay=0): go to DONE_CLEAN.
- State WRITE:
  - BusValid=1, EvictBusy=1.
  - BusAdr = latched address + beat×(BEATLEN/8). Arithmetic is modulo 2^PA_BITS.
  - BusWData = buffer bits [beat×BEATLEN +: BEATLEN], so beat 0 is the low word.
  - BusLast = (beat==BEATS-1).
  - A beat completes when BusValid&BusReady. On completion, the counter increments. When the last beat completes, go to DONE_DIRTY.
  - BusAdr, BusWData and BusValid stay stable while BusReady=0. There is no timeout.
- State DONE_DIRTY: for one cycle EvictDone=1, ClearDirty=1, ClearWay=latched way, EvictBusy=1. Then go to IDLE.
- State DONE_CLEAN: for one cycle EvictDone=1, ClearDirty=0, EvictBusy=1. Then go to IDLE.
- EvictReq in any state other than IDLE is ignored. No queueing.
- EvictReq in the same cycle that DONE_* returns to IDLE is also ignored. The next request is accepted one cycle after EvictDone.
- Multi-hot VictimWay is illegal. The assertion in the bench is that it never occurs. The RTL latches and returns the value unmodified.
- Latency:
  - Clean: EvictReq at cycle N → EvictDone at N+1.
  - Dirty with BusReady held at 1: first beat at N+1, last beat at N+BEATS, EvictDone/ClearDirty at N+BEATS+1.
- The buffer is loaded only on an accepted EvictReq. Input changes after that have no effect on the burst.

Test Plan:
- Clean victim: EvictReq with VictimDirty=0, VictimWay=4'b0100 → EvictDone at N+1, ClearDirty=0, BusValid never asserted.
- Dirty victim, BusReady=1 throughout, VictimAdr=0x8000_1000, VictimLine=0x4444…_3333…_2222…_1111… →
  - four beats at addresses 0x..1000, 0x..1008, 0x..1010, 0x..1018;
  - data 0x1111…, 0x2222…, 0x3333…, 0x4444… in that order;
  - BusLast only on the 4th beat;
  - ClearDirty with ClearWay=4'b0100 at N+5.
- Backpressure: same burst with BusReady low for 3 cycles on beat 1 → BusAdr/BusWData held steady on beat 1, no beat skipped or duplicated, EvictDone at N+8.
- Request while busy: second EvictReq (way 4'b0001) during beat 2 → ignored; ClearWay still reports the first way. A request accepted the cycle after EvictDone starts a new burst.
- Reset mid-burst: assert reset during beat 2 → BusValid=0 and EvictBusy=0 immediately. No EvictDone. A following clean EvictReq completes normally at N+1.
- Address wrap: VictimAdr=0xFFFF_FFE0 → beat addresses …FFE0, …FFE8, …FFF0, …FFF8 with no overflow corruption. Address wrap-around past 2^PA_BITS is covered by unit test of the adder with PA_BITS=8.

Source files
------------

// File: rtl/cache_victim_writeback_if.sv
// Victim-eviction bundle: cache-side request/ack signals plus the beat-wise bus write channel.
// Bus handshake: a beat transfers on every clock edge where BusValid && BusReady; while
// BusValid=1 and BusReady=0 the source holds BusAdr/BusWData/BusLast stable and never drops BusValid.
interface cache_victim_writeback_if #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64,
  parameter int PA_BITS = 32
);
  logic               EvictReq;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimDirty;
  logic [LINELEN-1:0] VictimLine;
  logic [PA_BITS-1:0] VictimAdr;
  logic               BusReady;
  logic               BusValid;
  logic [PA_BITS-1:0] BusAdr;
  logic [BEATLEN-1:0] BusWData;
  logic               BusLast;
  logic               EvictBusy;
  logic               EvictDone;
  logic               ClearDirty;
  logic [NUMWAYS-1:0] ClearWay;

  modport slave (
    input  EvictReq, VictimWay, VictimDirty, VictimLine, VictimAdr, BusReady,
    output BusValid, BusAdr, BusWData, BusLast, EvictBusy, EvictDone, ClearDirty, ClearWay
  );

  modport master (
    output EvictReq, VictimWay, VictimDirty, VictimLine, VictimAdr, BusReady,
    input  BusValid, BusAdr, BusWData, BusLast, EvictBusy, EvictDone, ClearDirty, ClearWay
  );
endinterface

// File: rtl/cache_victim_writeback.sv
// Victim writeback: buffers a dirty victim line, drains it as BEATS bus beats, then
// pulses EvictDone (and ClearDirty for dirty lines). Clean victims complete in one cycle.
module cache_victim_writeback #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64,
  parameter int PA_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_victim_writeback_if.slave bus,
  output logic [1:0]              dbg_state
);
  localparam int BEATS      = LINELEN / BEATLEN;
  localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = BEATLEN / 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    DONE_DIRTY = 2'd2,
    DONE_CLEAN = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      beat_cnt;
  logic [LINELEN-1:0] line_q;
  logic [PA_BITS-1:0] adr_q;
  logic [NUMWAYS-1:0] way_q;
  logic               accept_dirty;
  logic               beat_fire;
  logic               beat_last;
  logic [PA_BITS-1:0] beat_off;
  logic [BEATLEN-1:0] beat_data;

  assign accept_dirty = (state == IDLE) && bus.EvictReq && bus.VictimDirty &&
                        (bus.VictimWay != '0);
  assign beat_last    = (beat_cnt == CW'(BEATS - 1));
  assign beat_fire    = (state == WRITE) && bus.BusReady;
  // Offset is formed at full address width so the add wraps modulo 2^PA_BITS.
  assign beat_off     = PA_BITS'(beat_cnt) * PA_BITS'(BEAT_BYTES);

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_cnt == CW'(i)) beat_data = line_q[i*BEATLEN +: BEATLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Requests arriving outside IDLE (including the DONE_* cycle) are dropped, not queued.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept_dirty)      state_n = WRITE;
        else if (bus.EvictReq) state_n = DONE_CLEAN;
      end
      WRITE: begin
        if (beat_fire && beat_last) state_n = DONE_DIRTY;
      end
      DONE_DIRTY: state_n = IDLE;
      DONE_CLEAN: state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      line_q   <= '0;
      adr_q    <= '0;
      way_q    <= '0;
    end else if (accept_dirty) begin
      beat_cnt <= '0;
      line_q   <= bus.VictimLine;
      adr_q    <= bus.VictimAdr;
      way_q    <= bus.VictimWay;
    end else if (beat_fire) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
    end
  end

  assign bus.BusValid   = (state == WRITE);
  assign bus.BusAdr     = (state == WRITE) ? (adr_q + beat_off) : '0;
  assign bus.BusWData   = (state == WRITE) ? beat_data : '0;
  assign bus.BusLast    = (state == WRITE) && beat_last;
  assign bus.EvictBusy  = (state != IDLE);
  assign bus.EvictDone  = (state == DONE_DIRTY) || (state == DONE_CLEAN);
  assign bus.ClearDirty = (state == DONE_DIRTY);
  assign bus.ClearWay   = (state == DONE_DIRTY) ? way_q : '0;
  assign dbg_state      = state;
endmodule

// File: tb/tb_cache_victim_writeback.sv
// Bench for cache_victim_writeback: vector table of evictions, beat/done scoreboard,
// plus a hand-written reset-mid-burst sequence.
module tb_cache_victim_writeback;
  localparam int NW    = 4;
  localparam int LL    = 256;
  localparam int BL    = 64;
  localparam int PA    = 32;
  localparam int BEATS = LL / BL;
  localparam int BW    = 1 + PA + BL;
  localparam int DW    = 32 + 1 + NW;

  typedef struct {
    logic          dirty;
    logic [NW-1:0] way;
    logic [PA-1:0] adr;
    logic [LL-1:0] line;
    int            stall_beat;
    int            stall_len;
    int            busy_off;
    int            lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;

  logic [BW-1:0] exp_q[$];
  logic [DW-1:0] done_q[$];
  vec_t          vecs[7];

  cache_victim_writeback_if #(.NUMWAYS(NW), .LINELEN(LL), .BEATLEN(BL), .PA_BITS(PA)) vif ();

  cache_victim_writeback #(.NUMWAYS(NW), .LINELEN(LL), .BEATLEN(BL), .PA_BITS(PA)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (vif),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LL-1:0] rand_line();
    logic [LL-1:0] l;
    for (int i = 0; i < LL / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // scoreboard monitor, sampled on the falling edge
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat;
  always @(negedge clk) begin
    logic [BW-1:0] e;
    logic [DW-1:0] d;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (vif.EvictReq && !$onehot0(vif.VictimWay)) $error("multi-hot VictimWay driven");
      if (prev_stall) begin
        check("hold_valid", vif.BusValid, 1'b1);
        check("hold_beat", {vif.BusLast, vif.BusAdr, vif.BusWData}, prev_beat);
      end
      if (vif.BusValid) begin
        check("busy_in_write", vif.EvictBusy, 1'b1);
        if (vif.BusReady) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL beat_unexpected: got beat adr %0h expected no beat", vif.BusAdr);
          end else begin
            e = exp_q.pop_front();
            check("beat_adr", vif.BusAdr, e[BL +: PA]);
            check("beat_data", vif.BusWData, e[BL-1:0]);
            check("beat_last", vif.BusLast, e[BW-1]);
          end
        end
      end
      prev_stall = vif.BusValid && !vif.BusReady;
      prev_beat  = {vif.BusLast, vif.BusAdr, vif.BusWData};
      if (vif.EvictDone) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got EvictDone expected none (cycle %0d)", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 32'(cyc), d[DW-1 -: 32]);
          check("clear_dirty", vif.ClearDirty, d[NW]);
          if (d[NW]) check("clear_way", vif.ClearWay, d[NW-1:0]);
          check("done_busy", vif.EvictBusy, 1'b1);
          check("beats_left", exp_q.size(), 0);
        end
      end else begin
        check("clear_without_done", vif.ClearDirty, 1'b0);
      end
    end
  end

  // driver: entered and left just after a rising edge
  task automatic run_vec(input vec_t v);
    int   n, x, start;
    logic clear;
    n     = cyc;
    clear = v.dirty && (v.way != '0);
    vif.EvictReq    = 1'b1;
    vif.VictimDirty = v.dirty;
    vif.VictimWay   = v.way;
    vif.VictimAdr   = v.adr;
    vif.VictimLine  = v.line;
    vif.BusReady    = 1'b1;
    if (clear) begin
      for (int i = 0; i < BEATS; i++)
        exp_q.push_back({(i == BEATS - 1), v.adr + 32'(i * (BL / 8)), v.line[i*BL +: BL]});
    end
    done_q.push_back({32'(n + v.lat), clear, v.way});
    start = done_cnt;
    for (int k = 0; k < 40 && done_cnt == start; k++) begin
      @(posedge clk); #1;
      x = cyc;
      if (v.busy_off != 0 && x == n + v.busy_off) begin
        vif.EvictReq    = 1'b1;
        vif.VictimDirty = 1'b1;
        vif.VictimWay   = 4'b0001;
        vif.VictimAdr   = $urandom;
        vif.VictimLine  = rand_line();
      end else begin
        vif.EvictReq    = 1'b0;
        vif.VictimDirty = 1'($urandom_range(0, 1));
        vif.VictimWay   = NW'(1) << $urandom_range(0, NW - 1);
        vif.VictimAdr   = $urandom;
        vif.VictimLine  = rand_line();
      end
      vif.BusReady = !(v.stall_len > 0 && x >= n + 1 + v.stall_beat &&
                       x < n + 1 + v.stall_beat + v.stall_len);
    end
    if (done_cnt == start) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no EvictDone expected one by cycle %0d", n + v.lat);
      exp_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 4'b0100, 32'h1234_5640, rand_line(), 0, 0, 0, 1};
    vecs[1] = '{1'b1, 4'b0100, 32'h8000_1000,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0, 0, 5};
    vecs[2] = '{1'b1, 4'b0100, 32'h8000_1000,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 1, 3, 0, 8};
    vecs[3] = '{1'b1, 4'b0010, 32'hFFFF_FFE0, rand_line(), 0, 0, 0, 5};
    vecs[4] = '{1'b1, 4'b0000, 32'h0000_0100, rand_line(), 0, 0, 0, 1};
    vecs[5] = '{1'b1, 4'b0100, 32'h0000_2000, rand_line(), 0, 0, 3, 5};
    vecs[6] = '{1'b1, 4'b1000, 32'h4000_0040, rand_line(), 3, 2, 0, 7};

    reset           = 1'b1;
    vif.EvictReq    = 1'b0;
    vif.VictimDirty = 1'b0;
    vif.VictimWay   = '0;
    vif.VictimAdr   = '0;
    vif.VictimLine  = '0;
    vif.BusReady    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", vif.BusValid, 1'b0);
    check("rst_busy", vif.EvictBusy, 1'b0);
    check("rst_done", vif.EvictDone, 1'b0);
    check("rst_clear", vif.ClearDirty, 1'b0);
    check("rst_clearway", vif.ClearWay, 4'b0000);
    check("rst_last", vif.BusLast, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset during beat 2 of a dirty burst: only beats 0 and 1 ever transfer
    n = cyc;
    vif.EvictReq    = 1'b1;
    vif.VictimDirty = 1'b1;
    vif.VictimWay   = 4'b0010;
    vif.VictimAdr   = 32'h0000_3000;
    vif.VictimLine  = rand_line();
    vif.BusReady    = 1'b1;
    for (int i = 0; i < 2; i++)
      exp_q.push_back({1'b0, 32'h0000_3000 + 32'(i * 8), vif.VictimLine[i*BL +: BL]});
    @(posedge clk); #1;
    vif.EvictReq = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_beat2_valid", vif.BusValid, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midrst_valid", vif.BusValid, 1'b0);
    check("midrst_busy", vif.EvictBusy, 1'b0);
    check("midrst_done", vif.EvictDone, 1'b0);
    check("midrst_beats_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec('{1'b0, 4'b0001, 32'h0000_0040, rand_line(), 0, 0, 0, 1});

    repeat (3) @(posedge clk);
    #1;
    check("final_done_q", done_q.size(), 0);
    check("final_exp_q", exp_q.size(), 0);
    check("final_idle", vif.EvictBusy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
